// File: rtl/ldo_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// ldo_ramp_sequencer: slews per-channel LDO DAC codes toward their targets,
// one bounded step per SPI command word pushed into a downstream FIFO. Rev 1.0
// ============================================================================
module ldo_ramp_sequencer #(
  parameter int NUM_CH    = 8,
  parameter int CODE_W    = 11,
  parameter int STEP      = 16,
  parameter int DWELL_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              tgt_we,
  input  logic [2:0]        tgt_ch,
  input  logic [CODE_W-1:0] tgt_code,
  input  logic              cmd_full,
  output logic              cmd_wr_en,
  output logic [31:0]       cmd_wr_data,
  output logic              busy,
  output logic              settled
);

  localparam int                PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CODE_W-1:0] STEP_C  = CODE_W'(STEP);
  localparam logic [15:0]       DWELL_C = 16'(DWELL_CYC);
  localparam logic [PTR_W-1:0]  LAST_CH = PTR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    EMIT  = 2'd2,
    DWELL = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [CODE_W-1:0] tgt_q [NUM_CH];
  logic [CODE_W-1:0] cur_q [NUM_CH];
  logic [15:0]       dwell_q;
  logic [PTR_W-1:0]  ptr_q;   // channel following the last one served
  logic [PTR_W-1:0]  idx_q;   // channel under test this SCAN cycle
  logic [PTR_W-1:0]  miss_q;
  logic [PTR_W-1:0]  sel_q;
  logic [CODE_W-1:0] next_q;
  logic              cmd_wr_en_q;
  logic [31:0]       cmd_wr_data_q;

  logic [CODE_W-1:0] w_cur, w_tgt, w_diff, w_step, w_next;
  logic [PTR_W-1:0]  w_idx_inc;
  logic [7:0]        w_ss;
  logic              w_hit;
  logic              w_enter_scan, w_scan_adv, w_latch, w_emit;

  always_comb begin
    w_cur     = cur_q[idx_q];
    w_tgt     = tgt_q[idx_q];
    w_diff    = (w_tgt > w_cur) ? (w_tgt - w_cur) : (w_cur - w_tgt);
    w_step    = (w_diff > STEP_C) ? STEP_C : w_diff;
    w_next    = (w_tgt > w_cur) ? (w_cur + w_step) : (w_cur - w_step);
    w_idx_inc = (idx_q == LAST_CH) ? '0 : (idx_q + PTR_W'(1));
    w_ss      = 8'h01 << idx_q;
    w_hit     = ch_en[idx_q] && (w_cur != w_tgt);
  end

  always_comb begin
    state_d      = state_q;
    w_enter_scan = 1'b0;
    w_scan_adv   = 1'b0;
    w_latch      = 1'b0;
    w_emit       = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          state_d      = SCAN;
          w_enter_scan = 1'b1;
        end
      end
      SCAN: begin
        if (!run) begin
          state_d = IDLE;
        end else if (w_hit) begin
          state_d = EMIT;
          w_latch = 1'b1;
        end else if (miss_q == LAST_CH) begin
          state_d = IDLE;
        end else begin
          w_scan_adv = 1'b1;
        end
      end
      // run is deliberately ignored here so a started command always completes
      EMIT: begin
        if (!cmd_full) begin
          state_d = DWELL;
          w_emit  = 1'b1;
        end
      end
      DWELL: begin
        if (dwell_q == '0) begin
          if (run) begin
            state_d      = SCAN;
            w_enter_scan = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      dwell_q       <= '0;
      ptr_q         <= '0;
      idx_q         <= '0;
      miss_q        <= '0;
      sel_q         <= '0;
      next_q        <= '0;
      cmd_wr_en_q   <= 1'b0;
      cmd_wr_data_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        tgt_q[c] <= '0;
        cur_q[c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cmd_wr_en_q <= w_emit;

      for (int c = 0; c < NUM_CH; c++) begin
        if (tgt_we && (int'(tgt_ch) == c)) begin
          tgt_q[c] <= tgt_code;
        end
      end

      if (w_enter_scan) begin
        idx_q  <= ptr_q;
        miss_q <= '0;
      end else if (w_scan_adv) begin
        idx_q  <= w_idx_inc;
        miss_q <= miss_q + PTR_W'(1);
      end

      // The step is frozen here so later target writes wait for the next visit
      if (w_latch) begin
        sel_q         <= idx_q;
        next_q        <= w_next;
        ptr_q         <= w_idx_inc;
        cmd_wr_data_q <= {16'(w_next), 8'h00, w_ss};
      end

      if (w_emit) begin
        cur_q[sel_q] <= next_q;
        dwell_q      <= DWELL_C;
      end else if ((state_q == DWELL) && (dwell_q != '0)) begin
        dwell_q <= dwell_q - 16'd1;
      end
    end
  end

  always_comb begin
    settled = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      if (ch_en[c] && (cur_q[c] != tgt_q[c])) begin
        settled = 1'b0;
      end
    end
  end

  assign cmd_wr_en   = cmd_wr_en_q;
  assign cmd_wr_data = cmd_wr_data_q;
  assign busy        = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ldo_ramp_sequencer.sv
`default_nettype none
// ============================================================================
// tb_ldo_ramp_sequencer: directed stimulus with a channel-level reference model
// of the ramp rules checked on every cycle. Rev 1.0
// ============================================================================
module tb_ldo_ramp_sequencer;

  localparam int NUM_CH    = 8;
  localparam int CODE_W    = 11;
  localparam int STEP      = 16;
  localparam int DWELL_CYC = 4;

  logic              clk;
  logic              rst;
  logic              run;
  logic [NUM_CH-1:0] ch_en;
  logic              tgt_we;
  logic [2:0]        tgt_ch;
  logic [CODE_W-1:0] tgt_code;
  logic              cmd_full;
  logic              cmd_wr_en;
  logic [31:0]       cmd_wr_data;
  logic              busy;
  logic              settled;

  ldo_ramp_sequencer #(
    .NUM_CH    (NUM_CH),
    .CODE_W    (CODE_W),
    .STEP      (STEP),
    .DWELL_CYC (DWELL_CYC)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .ch_en       (ch_en),
    .tgt_we      (tgt_we),
    .tgt_ch      (tgt_ch),
    .tgt_code    (tgt_code),
    .cmd_full    (cmd_full),
    .cmd_wr_en   (cmd_wr_en),
    .cmd_wr_data (cmd_wr_data),
    .busy        (busy),
    .settled     (settled)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: channel codes, targets and the round-robin start point.
  int          mtgt [NUM_CH];
  int          mcur [NUM_CH];
  int          mptr;
  int          cyc;
  int          last_wr;
  bit          started;
  logic [31:0] got_q [$];

  function automatic logic model_settled();
    for (int c = 0; c < NUM_CH; c++)
      if (ch_en[c] && (mcur[c] != mtgt[c])) return 1'b0;
    return 1'b1;
  endfunction

  always begin
    int found;
    int t;
    int c;
    int nxt;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) started = 1'b1;
    if (started) begin
      if (rst) begin
        for (int k = 0; k < NUM_CH; k++) begin
          mtgt[k] = 0;
          mcur[k] = 0;
        end
        mptr    = 0;
        last_wr = -1000;
        chk("rst_wr_en", {31'b0, cmd_wr_en}, 32'd0);
      end else begin
        if (cmd_wr_en) begin
          found = -1;
          for (int k = 0; k < NUM_CH; k++) begin
            c = (mptr + k) % NUM_CH;
            if (found < 0 && ch_en[c] && mcur[c] != mtgt[c]) found = c;
          end
          if (found < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_write actual=%h required=no write", cmd_wr_data);
          end else begin
            t = mtgt[found];
            c = mcur[found];
            if (t > c) nxt = c + ((t - c) < STEP ? (t - c) : STEP);
            else       nxt = c - ((c - t) < STEP ? (c - t) : STEP);
            chk("model_word", cmd_wr_data, 32'((nxt << 16) | (1 << found)));
            mcur[found] = nxt;
            mptr        = (found + 1) % NUM_CH;
          end
          chk("write_gap_ok", {31'b0, (cyc - last_wr) >= (DWELL_CYC + 2)}, 32'd1);
          last_wr = cyc;
          got_q.push_back(cmd_wr_data);
        end
        if (tgt_we && int'(tgt_ch) < NUM_CH) mtgt[tgt_ch] = int'(tgt_code);
      end
      chk("settled", {31'b0, settled}, {31'b0, model_settled()});
    end
  end

  task automatic set_tgt(input int ch, input int code);
    @(negedge clk);
    tgt_we   = 1'b1;
    tgt_ch   = 3'(ch);
    tgt_code = CODE_W'(code);
    @(negedge clk);
    tgt_we   = 1'b0;
  endtask

  task automatic wait_writes(input int n, input int budget, input string name);
    int k = 0;
    while (got_q.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(got_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input int budget, input string name);
    int k = 0;
    while (busy !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(name, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int base;
    rst      = 1'b1;
    run      = 1'b0;
    ch_en    = 8'hFF;
    tgt_we   = 1'b0;
    tgt_ch   = 3'd0;
    tgt_code = '0;
    cmd_full = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_wr_en",   {31'b0, cmd_wr_en}, 32'd0);
    chk("reset_wr_data", cmd_wr_data,        32'd0);
    chk("reset_busy",    {31'b0, busy},      32'd0);
    chk("reset_settled", {31'b0, settled},   32'd1);
    rst = 1'b0;

    // Ramp ch2 up to 40 in three steps
    set_tgt(2, 40);
    chk("settled_after_tgt", {31'b0, settled}, 32'd0);
    run = 1'b1;
    wait_writes(3, 200, "ramp_up_count");
    if (got_q.size() >= 3) begin
      chk("ramp_up_w0", got_q[0], 32'h0010_0004);
      chk("ramp_up_w1", got_q[1], 32'h0020_0004);
      chk("ramp_up_w2", got_q[2], 32'h0028_0004);
    end
    repeat (30) @(negedge clk);
    chk("ramp_up_no_extra", 32'(got_q.size()), 32'd3);
    run = 1'b0;
    wait_idle(50, "ramp_up_idle");
    chk("ramp_up_settled", {31'b0, settled}, 32'd1);

    // Ramp ch2 back down to 8
    set_tgt(2, 8);
    run = 1'b1;
    wait_writes(5, 200, "ramp_down_count");
    if (got_q.size() >= 5) begin
      chk("ramp_down_w0", got_q[3], 32'h0018_0004);
      chk("ramp_down_w1", got_q[4], 32'h0008_0004);
    end
    run = 1'b0;
    wait_idle(50, "ramp_down_idle");

    // Two channels pending: round-robin interleave
    set_tgt(0, 16);
    set_tgt(1, 32);
    run = 1'b1;
    wait_writes(8, 300, "rr_count");
    if (got_q.size() >= 8) begin
      chk("rr_w0", got_q[5], 32'h0010_0001);
      chk("rr_w1", got_q[6], 32'h0010_0002);
      chk("rr_w2", got_q[7], 32'h0020_0002);
    end
    run = 1'b0;
    wait_idle(50, "rr_idle");

    // FIFO back-pressure while holding in EMIT
    cmd_full = 1'b1;
    set_tgt(4, 5);
    run = 1'b1;
    repeat (8) @(negedge clk);
    base = got_q.size();
    for (int i = 0; i < 10; i++) begin
      chk("full_no_strobe", {31'b0, cmd_wr_en}, 32'd0);
      chk("full_data_held", cmd_wr_data,        32'h0005_0010);
      chk("full_busy",      {31'b0, busy},      32'd1);
      @(negedge clk);
    end
    chk("full_no_write", 32'(got_q.size()), 32'(base));
    cmd_full = 1'b0;
    repeat (20) @(negedge clk);
    chk("full_one_write", 32'(got_q.size()), 32'(base + 1));
    if (got_q.size() == base + 1) chk("full_word", got_q[base], 32'h0005_0010);
    run = 1'b0;
    wait_idle(50, "full_idle");

    // Reset in the middle of a dwell
    set_tgt(5, 200);
    run  = 1'b1;
    base = got_q.size();
    wait_writes(base + 1, 100, "mid_rst_first");
    if (got_q.size() == base + 1) chk("mid_rst_w0", got_q[base], 32'h0010_0020);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    chk("mid_rst_no_write", 32'(got_q.size()), 32'(base + 1));
    chk("mid_rst_busy",     {31'b0, busy},     32'd0);
    chk("mid_rst_settled",  {31'b0, settled},  32'd1);
    set_tgt(5, 16);
    run = 1'b1;
    wait_writes(base + 2, 100, "post_rst_write");
    if (got_q.size() >= base + 2) chk("post_rst_word", got_q[base + 1], 32'h0010_0020);
    repeat (30) @(negedge clk);
    chk("post_rst_single", 32'(got_q.size()), 32'(base + 2));
    run = 1'b0;
    wait_idle(50, "final_idle");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ldo_ramp_sequencer.md
LDO_RAMP_SEQUENCER -- requirements
Module: ldo_ramp_sequencer

Parameters
REQ-001 SHALL provide parameter NUM_CH, default 8, meaning number of LDO channels; each channel maps to one SPI_SS bit.
REQ-002 SHALL provide parameter CODE_W, default 11, meaning width of a DAC code; it equals the downstream SPI data length.
REQ-003 SHALL provide parameter STEP, default 16, meaning maximum code change per command; legal range 1..2^CODE_W-1.
REQ-004 SHALL provide parameter DWELL_CYC, default 1024, meaning idle clk cycles after each command; 16-bit; covers one SPI transaction plus settling.

Interface
REQ-005 SHALL have port clk, input, 1 bit: single clock; also drives the write clock of the downstream command FIFO.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-007 SHALL have port run, input, 1 bit: level enable for ramping.
REQ-008 SHALL have port ch_en, input, NUM_CH bits: per-channel enable mask.
REQ-009 SHALL have port tgt_we, input, 1 bit: target write strobe.
REQ-010 SHALL have port tgt_ch, input, 3 bits: target channel index.
REQ-011 SHALL have port tgt_code, input, CODE_W bits: target code.
REQ-012 SHALL have port cmd_full, input, 1 bit: command FIFO full.
REQ-013 SHALL have port cmd_wr_en, output, 1 bit: one-cycle FIFO write strobe.
REQ-014 SHALL have port cmd_wr_data, output, 32 bits: command word.
REQ-015 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port settled, output, 1 bit: high when every enabled channel has cur == tgt.

Function
REQ-017 SHALL format the command word as cmd_wr_data[31:16] = {zero pad, code[CODE_W-1:0]} and cmd_wr_data[15:0] = {8'h00, one-hot SS bit of the channel}; the upper half is the first 16-bit FIFO read (data) and the lower half is the second (SS).
REQ-018 SHALL hold per-channel registers tgt[ch] and cur[ch], both CODE_W bits.
REQ-019 SHALL, when tgt_we=1 and tgt_ch<NUM_CH, update tgt[tgt_ch] on the next clk edge; tgt_ch>=NUM_CH SHALL be ignored.
REQ-020 SHALL implement states IDLE, SCAN, EMIT and DWELL.
REQ-021 SHALL, in IDLE, go to SCAN when run=1.
REQ-022 SHALL, in SCAN, test one channel per cycle, round-robin, starting at the channel after the last one served.
REQ-023 SHALL, in SCAN, latch a channel that has ch_en=1 and cur!=tgt and go to EMIT.
REQ-024 SHALL, in SCAN, return to IDLE after NUM_CH consecutive non-matching channels or when run=0.
REQ-025 SHALL compute the next code in EMIT: if tgt>cur, next = cur + min(STEP, tgt-cur); else next = cur - min(STEP, cur-tgt); no overflow or wrap; the result lands exactly on tgt.
REQ-026 SHALL, in EMIT with cmd_full=0, pulse cmd_wr_en for exactly one cycle with cmd_wr_data carrying the next code, write cur <= next, load the dwell counter with DWELL_CYC, and go to DWELL.
REQ-027 SHALL, in EMIT with cmd_full=1, hold the state with cmd_wr_en=0 and cmd_wr_data stable.
REQ-028 SHALL decrement the dwell counter in DWELL; at 0 it SHALL go to SCAN if run=1, else to IDLE.
REQ-029 SHALL NOT abort an EMIT already in progress when run deasserts.
REQ-030 SHALL compute the EMIT step from the tgt value latched on entry to EMIT; a tgt write to the same channel during EMIT or DWELL SHALL apply on that channel's next visit.
REQ-031 SHALL produce a new command no sooner than DWELL_CYC+2 cycles after the previous cmd_wr_en.
REQ-032 SHALL drive settled combinationally from the cur, tgt and ch_en registers; disabled channels SHALL count as settled.
REQ-033 SHALL drive cmd_wr_en and cmd_wr_data from registers, with no combinational path from inputs.

Reset
REQ-034 SHALL, at rst=1 on a clk edge, set state=IDLE and clear all tgt, all cur, the dwell counter and the round-robin pointer (next scan starts at ch0).
REQ-035 SHALL, at reset, drive cmd_wr_en=0, cmd_wr_data=0, busy=0 and settled=1.
REQ-036 SHALL, on reset asserted mid-EMIT or mid-DWELL, clear all state with no write strobe emitted in the reset cycle or after it.

Verification (STEP=16, DWELL_CYC=4 in the bench)
REQ-037 Bench SHALL cover: rst 2 cycles -> cmd_wr_en=0, cmd_wr_data=0, busy=0, settled=1.
REQ-038 Bench SHALL cover: tgt[2]=40, ch_en=8'hFF, run=1 -> exactly 3 writes 32'h0010_0004, 32'h0020_0004, 32'h0028_0004, gaps >=6 cycles, then settled=1 and busy=0.
REQ-039 Bench SHALL cover: after REQ-038, tgt[2]=8 -> writes 32'h0018_0004, 32'h0008_0004.
REQ-040 Bench SHALL cover: tgt[0]=16 and tgt[1]=32 written together -> order 32'h0010_0001, 32'h0010_0002, 32'h0020_0002.
REQ-041 Bench SHALL cover: cmd_full=1 for 10 cycles while in EMIT -> no strobe, data held; exactly one strobe after release.
REQ-042 Bench SHALL cover: rst mid-DWELL with tgt[5]=200 -> no further writes; then tgt[5]=16 and run -> single write 32'h0010_0020.
